// File: rtl/spi_device_shift_engine.sv
// spi_device_shift_engine: device-side SPI mode-0 shift engine (Standard/Dual/Quad).
// Oversamples the pad SCK/CSB/SD in clk_i, packs received bits into bytes on an
// RX valid/ready stream and serialises bytes fetched from a TX valid/ready stream.
// Optional feature macro: SPI_DEVICE_BYTE_COUNT_EN adds byte_cnt_o, a saturating
// count of bytes completed in the current/last transaction.
module spi_device_shift_engine #(
    parameter int SyncStages = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sw_rst_i,
    input  logic [1:0]  speed_i,
    input  logic        tx_en_i,
    input  logic        sck_i,
    input  logic        csb_i,
    input  logic [3:0]  sd_i,
    output logic [3:0]  sd_o,
    output logic [3:0]  sd_en_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        txn_active_o,
    output logic        txn_end_o,
    output logic        partial_o,
    output logic        overflow_o,
    output logic        underflow_o
`ifdef SPI_DEVICE_BYTE_COUNT_EN
    ,
    output logic [15:0] byte_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [SyncStages-1:0]      sck_sync, csb_sync;
    logic [SyncStages-1:0][3:0] sd_sync;
    logic                       sck_prev, csb_prev;
    logic                       sck_q, csb_q;
    logic [3:0]                 sd_q;

    logic [1:0] state;
    logic [2:0] edge_cnt;
    logic [7:0] tx_sr, rx_sr;

    logic       speed_ok, in_active, rise, fall, byte_done, rx_drain, fetch;
    logic [3:0] bpe;
    logic [2:0] last_edge;
    logic [7:0] rx_shift, tx_fill;

    assign sck_q = sck_sync[SyncStages-1];
    assign csb_q = csb_sync[SyncStages-1];
    assign sd_q  = sd_sync[SyncStages-1];

    // Pad-side synchronisers; CSB presets high so reset looks like "no transaction".
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
            csb_prev <= 1'b1;
        end else if (sw_rst_i) begin
            sck_sync <= '0;
            csb_sync <= '1;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
            csb_prev <= 1'b1;
        end else begin
            sck_sync <= {sck_sync[SyncStages-2:0], sck_i};
            csb_sync <= {csb_sync[SyncStages-2:0], csb_i};
            sd_sync  <= {sd_sync[SyncStages-2:0], sd_i};
            sck_prev <= sck_q;
            csb_prev <= csb_q;
        end
    end

    // Per-speed geometry, edge detection and the next RX shift value.
    always_comb begin
        speed_ok  = (speed_i != 2'd3);
        bpe       = 4'd1;
        last_edge = 3'd7;
        rx_shift  = {rx_sr[6:0], sd_q[0]};
        case (speed_i)
            2'd1: begin bpe = 4'd2; last_edge = 3'd3; rx_shift = {rx_sr[5:0], sd_q[1:0]}; end
            2'd2: begin bpe = 4'd4; last_edge = 3'd1; rx_shift = {rx_sr[3:0], sd_q[3:0]}; end
            default: ;
        endcase
        // A CSB deassert seen in the same cycle as an SCK edge suppresses the edge.
        in_active = (state == ST_ACTIVE) && !csb_q && speed_ok;
        rise      = in_active && sck_q && !sck_prev;
        fall      = in_active && !sck_q && sck_prev;
        byte_done = rise && (edge_cnt == last_edge);
        rx_drain  = rx_valid_o && rx_ready_i;
        fetch     = ((state == ST_LOAD) && speed_ok) || (fall && (edge_cnt == 3'd0));
        tx_fill   = tx_valid_i ? tx_data_i : 8'hFF;
    end

    // Transaction FSM, shift registers, RX buffer and status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            tx_ready_o  <= 1'b0;
            underflow_o <= 1'b0;
            overflow_o  <= 1'b0;
            txn_end_o   <= 1'b0;
            partial_o   <= 1'b0;
        end else if (sw_rst_i) begin
            state       <= ST_IDLE;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data_o   <= '0;
            rx_valid_o  <= 1'b0;
            tx_ready_o  <= 1'b0;
            underflow_o <= 1'b0;
            overflow_o  <= 1'b0;
            txn_end_o   <= 1'b0;
            partial_o   <= 1'b0;
        end else begin
            tx_ready_o  <= fetch && tx_valid_i;
            underflow_o <= fetch && !tx_valid_i;
            overflow_o  <= 1'b0;
            txn_end_o   <= 1'b0;
            partial_o   <= 1'b0;
            case (state)
                ST_IDLE: if (csb_prev && !csb_q) state <= ST_LOAD;
                ST_LOAD: begin
                    state    <= ST_ACTIVE;
                    edge_cnt <= '0;
                    rx_sr    <= '0;
                    tx_sr    <= speed_ok ? tx_fill : 8'hFF;
                end
                ST_ACTIVE: begin
                    if (csb_q) begin
                        state     <= ST_IDLE;
                        txn_end_o <= 1'b1;
                        partial_o <= (edge_cnt != 3'd0);
                    end
                    if (rise) begin
                        rx_sr    <= rx_shift;
                        edge_cnt <= byte_done ? 3'd0 : edge_cnt + 3'd1;
                    end
                    if (fall) tx_sr <= (edge_cnt == 3'd0) ? tx_fill : (tx_sr << bpe);
                end
                default: state <= ST_IDLE;
            endcase
            if (byte_done) begin
                if (!rx_valid_o || rx_drain) begin
                    rx_data_o  <= rx_shift;
                    rx_valid_o <= 1'b1;
                end else begin
                    overflow_o <= 1'b1;
                end
            end else if (rx_drain) begin
                rx_valid_o <= 1'b0;
            end
        end
    end

`ifdef SPI_DEVICE_BYTE_COUNT_EN
    logic [15:0] byte_cnt_q;
    assign byte_cnt_o = byte_cnt_q;

    // Bytes completed since LOAD, dropped ones included; saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   byte_cnt_q <= '0;
        else if (sw_rst_i)                             byte_cnt_q <= '0;
        else if (state == ST_LOAD)                     byte_cnt_q <= '0;
        else if (byte_done && byte_cnt_q != 16'hFFFF)  byte_cnt_q <= byte_cnt_q + 16'd1;
    end
`endif

    assign txn_active_o = !csb_q;

    // Output lines are a pure function of the TX shift register MSBs.
    always_comb begin
        sd_o    = 4'h0;
        sd_en_o = 4'h0;
        case (speed_i)
            2'd0: begin sd_o = {2'b00, tx_sr[7], 1'b0}; sd_en_o = 4'b0010; end
            2'd1: begin sd_o = {2'b00, tx_sr[7:6]};     sd_en_o = 4'b0011; end
            2'd2: begin sd_o = tx_sr[7:4];              sd_en_o = 4'b1111; end
            default: ;
        endcase
        if (!(txn_active_o && tx_en_i)) sd_en_o = 4'h0;
    end

endmodule

// File: tb/tb_spi_device_shift_engine.sv
// tb_spi_device_shift_engine: host-side SPI mode-0 driver with a byte-level reference
// model of what the device should return, fetch and report per transaction.
module tb_spi_device_shift_engine;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       sw_rst_i = 1'b0;
    logic [1:0] speed_i = 2'd0;
    logic       tx_en_i = 1'b1;
    logic       sck_i = 1'b0;
    logic       csb_i = 1'b1;
    logic [3:0] sd_i = 4'h0;
    logic [3:0] sd_o, sd_en_o;
    logic [7:0] tx_data_i;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i = 1'b1;
    logic       txn_active_o, txn_end_o, partial_o, overflow_o, underflow_o;
`ifdef SPI_DEVICE_BYTE_COUNT_EN
    logic [15:0] byte_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    spi_device_shift_engine #(.SyncStages(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sw_rst_i(sw_rst_i), .speed_i(speed_i),
        .tx_en_i(tx_en_i), .sck_i(sck_i), .csb_i(csb_i), .sd_i(sd_i),
        .sd_o(sd_o), .sd_en_o(sd_en_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ready_i(rx_ready_i), .txn_active_o(txn_active_o), .txn_end_o(txn_end_o),
        .partial_o(partial_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
`ifdef SPI_DEVICE_BYTE_COUNT_EN
        , .byte_cnt_o(byte_cnt_o)
`endif
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Stimulus bytes: what the device should transmit (tx_q) and what the host sends (rx_b).
    logic [7:0] tx_q [16];
    logic [7:0] rx_b [16];

    // Event log collected away from the clock edge; bases are snapshots per transaction.
    int c_rdy = 0, c_unf = 0, c_ovf = 0, c_end = 0, c_part = 0, c_pe = 0, rx_cnt = 0;
    int b_rdy, b_unf, b_ovf, b_end, b_part, b_pe, b_rx;
    int rdy_base = 0;
    logic [7:0] rx_log [1024];

    logic [31:0] rdy_off;
    assign rdy_off   = 32'(c_rdy - rdy_base);
    assign tx_data_i = tx_q[rdy_off[3:0]];

    always @(negedge clk_i) begin
        if (tx_ready_o)             c_rdy++;
        if (underflow_o)            c_unf++;
        if (overflow_o)             c_ovf++;
        if (txn_end_o)              c_end++;
        if (partial_o)              c_part++;
        if (partial_o && txn_end_o) c_pe++;
        if (rx_valid_o && rx_ready_i) begin
            rx_log[rx_cnt % 1024] = rx_data_o;
            rx_cnt++;
        end
    end

    task automatic snap();
        b_rdy = c_rdy; b_unf = c_unf; b_ovf = c_ovf; b_end = c_end;
        b_part = c_part; b_pe = c_pe; b_rx = rx_cnt; rdy_base = c_rdy;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One host transaction of nr rising edges; CSB is raised while SCK is still high.
    task automatic run_txn(input int spd, input int nr, input bit txv, input bit rxr, input bit ten);
        int bpe, epb, mask, b, c, sh, fetches, done;
        logic [7:0] tb_byte;
        logic [3:0] tv, exp_sd, exp_en;
        bpe  = (spd == 1) ? 2 : (spd == 2) ? 4 : 1;
        epb  = 8 / bpe;
        mask = (1 << bpe) - 1;
        exp_en = !ten ? 4'h0 : (spd == 0) ? 4'b0010 : (spd == 1) ? 4'b0011 :
                 (spd == 2) ? 4'b1111 : 4'h0;
        @(negedge clk_i);
        speed_i = 2'(spd); tx_valid_i = txv; rx_ready_i = rxr; tx_en_i = ten;
        snap();
        csb_i = 1'b0;
        wait_n(8);
        for (int r = 0; r < nr; r++) begin
            b  = r / epb;
            c  = r % epb;
            sh = 8 - bpe * (c + 1);
            sd_i = 4'(($urandom & ~mask) | ((int'(rx_b[b]) >> sh) & mask));
            wait_n(8);
            tb_byte = txv ? tx_q[b] : 8'hFF;
            tv = 4'((int'(tb_byte) >> sh) & mask);
            exp_sd = (spd == 0) ? {2'b00, tv[0], 1'b0} : tv;
            if (spd != 3) chk($sformatf("sd_o r%0d", r), 32'(sd_o), 32'(exp_sd));
            chk($sformatf("sd_en_o r%0d", r), 32'(sd_en_o), 32'(exp_en));
            sck_i = 1'b1;
            wait_n(8);
            if (r != nr - 1) sck_i = 1'b0;
        end
        csb_i = 1'b1;
        wait_n(8);
        sck_i = 1'b0;
        wait_n(12);
        done    = (spd == 3) ? 0 : nr / epb;
        fetches = (spd == 3) ? 0 : 1 + (nr - 1) / epb;
        chk("txn_end cnt", 32'(c_end - b_end), 32'd1);
        chk("tx_ready cnt", 32'(c_rdy - b_rdy), 32'(txv ? fetches : 0));
        if (spd != 3) chk("underflow cnt", 32'(c_unf - b_unf), 32'(txv ? 0 : fetches));
        chk("partial cnt", 32'(c_part - b_part), 32'((spd != 3 && nr % epb != 0) ? 1 : 0));
        chk("partial w/ end", 32'(c_pe - b_pe), 32'(c_part - b_part));
`ifdef SPI_DEVICE_BYTE_COUNT_EN
        chk("byte_cnt_o", 32'(byte_cnt_o), 32'(done));
`endif
        if (rxr) begin
            chk("rx cnt", 32'(rx_cnt - b_rx), 32'(done));
            for (int i = 0; i < done && i < rx_cnt - b_rx; i++)
                chk($sformatf("rx byte %0d", i), 32'(rx_log[(b_rx + i) % 1024]), 32'(rx_b[i]));
            chk("overflow cnt", 32'(c_ovf - b_ovf), 32'd0);
        end else begin
            chk("rx cnt held", 32'(rx_cnt - b_rx), 32'd0);
            chk("overflow cnt", 32'(c_ovf - b_ovf), 32'(done > 1 ? done - 1 : 0));
            chk("rx_valid held", 32'(rx_valid_o), 32'(done > 0 ? 1 : 0));
            if (done > 0) begin
                @(posedge clk_i); #1 rx_ready_i = 1'b1;
                @(posedge clk_i); #1 rx_ready_i = 1'b0;
                wait_n(2);
                chk("drain cnt", 32'(rx_cnt - b_rx), 32'd1);
                chk("drain byte", 32'(rx_log[b_rx % 1024]), 32'(rx_b[0]));
            end
        end
        chk("rx_valid idle", 32'(rx_valid_o), 32'd0);
    endtask

    function automatic logic [31:0] out_vec();
        return {sd_o, sd_en_o, rx_data_o, rx_valid_o, tx_ready_o, txn_active_o,
                txn_end_o, partial_o, overflow_o, underflow_o};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin tx_q[i] = 8'($urandom); rx_b[i] = 8'($urandom); end
        wait_n(3);
        chk("reset outputs", out_vec(), 32'd0);
        rst_ni = 1'b1;
        wait_n(5);
        chk("post-reset outputs", out_vec(), 32'd0);

        // Standard, A5 out, 3C in.
        tx_q[0] = 8'hA5; rx_b[0] = 8'h3C;
        run_txn(0, 8, 1'b1, 1'b1, 1'b1);
        // Quad, two bytes each way.
        tx_q[0] = 8'h12; tx_q[1] = 8'h34; rx_b[0] = 8'h5A; rx_b[1] = 8'hC3;
        run_txn(2, 4, 1'b1, 1'b1, 1'b1);
        // Standard, consumer stalled: second byte overflows.
        rx_b[0] = 8'h11; rx_b[1] = 8'h22;
        run_txn(0, 16, 1'b1, 1'b0, 1'b1);
        // Dual, nothing to send: all ones, two underflows.
        run_txn(1, 8, 1'b0, 1'b1, 1'b1);
        // Standard partial byte.
        run_txn(0, 5, 1'b1, 1'b1, 1'b1);
        // Reserved speed: engine stays quiet.
        run_txn(3, 8, 1'b1, 1'b1, 1'b1);

        // Async reset mid-byte (Quad, one rise), then a clean transaction.
        @(negedge clk_i);
        speed_i = 2'd2; tx_valid_i = 1'b1; tx_en_i = 1'b1; rx_ready_i = 1'b1;
        snap();
        csb_i = 1'b0; wait_n(8);
        sd_i = 4'h9; wait_n(8);
        sck_i = 1'b1; wait_n(8);
        chk("pre-reset sd_en", 32'(sd_en_o), 32'hF);
        rst_ni = 1'b0;
        #1 chk("mid-byte reset outputs", out_vec(), 32'd0);
        csb_i = 1'b1; sck_i = 1'b0;
        wait_n(4);
        rst_ni = 1'b1;
        wait_n(4);
        rx_b[0] = 8'h7E;
        run_txn(2, 2, 1'b1, 1'b1, 1'b1);

        // Randomised transactions.
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) begin tx_q[i] = 8'($urandom); rx_b[i] = 8'($urandom); end
            run_txn(int'($urandom_range(0, 2)), int'($urandom_range(1, 20)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_device_shift_engine.md
Name: spi_device_shift_engine

Overview:
Target-side (device) serial engine for the SPI link; it is the counterpart to the host shift register.
- Oversamples SCK/CSB/SD from the pad side in the clk_i domain.
- Deserialises incoming bits into bytes on a valid/ready RX stream.
- Serialises bytes fetched from a TX valid/ready stream onto the output data lines.
- Supports SPI mode 0 only (CPOL=0, CPHA=0) in Standard, Dual and Quad speed.

Parameters:
SyncStages, 2, number of flops in each SCK/CSB/SD input synchroniser (minimum 2)

Ports:
clk_i  input  1  system clock; must run at least 8x the SCK frequency
rst_ni  input  1  asynchronous active-low reset
sw_rst_i  input  1  synchronous soft reset; same effect as rst_ni
speed_i  input  2  0=Standard, 1=Dual, 2=Quad, 3=reserved (RX and TX idle)
tx_en_i  input  1  allow the engine to drive sd lines during a transaction
sck_i  input  1  raw SPI clock from pad
csb_i  input  1  raw chip select from pad, active low
sd_i  input  4  raw data lines from pad
sd_o  output  4  data out to pad
sd_en_o  output  4  per-line output enable
tx_data_i  input  8  next byte to transmit
tx_valid_i  input  1  tx_data_i is valid
tx_ready_o  output  1  one-cycle pulse: tx_data_i consumed
rx_data_o  output  8  received byte
rx_valid_o  output  1  rx_data_o is valid
rx_ready_i  input  1  consumer accepts rx_data_o
txn_active_o  output  1  synchronised CSB is asserted
txn_end_o  output  1  one-cycle pulse on CSB deassertion
partial_o  output  1  one-cycle pulse with txn_end_o when a partial RX byte is discarded
overflow_o  output  1  one-cycle pulse: completed RX byte dropped because the buffer is full
underflow_o  output  1  one-cycle pulse: TX byte needed but tx_valid_i low

Behaviour:
- Reset (rst_ni low or sw_rst_i high):
  - all outputs 0, except sd_o = 4'h0 and sd_en_o = 4'h0
  - synchronisers cleared, with the CSB synchroniser preset to 1 (inactive)
  - edge counter, shift registers and RX buffer cleared
- Input synchronisation: sck_i, csb_i and sd_i each pass through SyncStages flops.
  - rise = sync_sck & ~sck_prev; fall = ~sync_sck & sck_prev.
  - Edges are ignored while sync CSB is high.
- Bits per edge (bpe): 1/2/4 for Standard/Dual/Quad.
- Edges per byte (epb): 8/4/2.
- edge_cnt counts rise events modulo epb; it wraps to 0 on byte completion.
- State machine, IDLE -> LOAD -> ACTIVE -> IDLE:
  - IDLE: waits for sync CSB falling.
  - LOAD: one cycle. If tx_valid_i, load tx_sr <= tx_data_i and pulse tx_ready_o; else load tx_sr <= 8'hFF and pulse underflow_o. Clear edge_cnt and rx_sr.
  - ACTIVE: runs until sync CSB rises, then goes to IDLE, pulses txn_end_o, and pulses partial_o if edge_cnt != 0. The partial byte is discarded.
- RX path, on rise:
  - Standard: rx_sr <= {rx_sr[6:0], sd_q[0]}.
  - Dual: rx_sr <= {rx_sr[5:0], sd_q[1:0]}.
  - Quad: rx_sr <= {rx_sr[3:0], sd_q[3:0]}.
  - When edge_cnt == epb-1, the shifted value goes to the 1-deep RX buffer in the same cycle.
- RX buffer:
  - If empty, or being drained this cycle (rx_valid_o & rx_ready_i), the byte is written and rx_valid_o = 1 next cycle.
  - Otherwise the new byte is dropped, the buffer is kept, and overflow_o pulses.
  - rx_valid_o stays high until accepted; it is not cleared by CSB deassertion.
- TX path, on fall:
  - If edge_cnt == 0 (byte boundary just passed), reload tx_sr using the same valid/underflow rule as LOAD.
  - Otherwise tx_sr <= tx_sr << bpe.
- sd_o (combinational from tx_sr):
  - Standard: {2'b00, tx_sr[7], 1'b0}.
  - Dual: {2'b00, tx_sr[7:6]}.
  - Quad: tx_sr[7:4].
- sd_en_o = 4'b0010 / 4'b0011 / 4'b1111 per speed when txn_active_o & tx_en_i; else 4'h0.
- Reserved speed: no RX pushes, no TX fetches, sd_en_o = 0.
- Simultaneous RX push and consumer drain in the same cycle: both take effect with no overflow.
- CSB deassert and rise in the same synchronised cycle: the rise is ignored.

Optional Feature:
Macro SPI_DEVICE_BYTE_COUNT_EN.
- Defined: adds output byte_cnt_o [15:0].
  - Cleared in LOAD.
  - Increments on each completed RX byte, whether or not it was dropped.
  - Saturates at 16'hFFFF.
  - Holds its value after txn_end_o.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan:
- Standard, tx_data_i=8'hA5 valid, host sends 8'h3C then raises CSB -> sd_o[1] sequence 1,0,1,0,0,1,0,1; rx_data_o=8'h3C with rx_valid_o; txn_end_o pulse; partial_o=0.
- Quad, host sends 8'h5A and 8'hC3, rx_ready_i held 1, tx bytes 8'h12 then 8'h34 -> sd_o nibbles 1,2,3,4; rx bytes 5A, C3; two tx_ready_o pulses.
- Standard, rx_ready_i=0, host sends 8'h11, 8'h22 -> rx_data_o stays 8'h11; overflow_o pulses once at the 16th rise; byte_cnt_o=2 when the macro is defined.
- tx_valid_i=0 throughout, Dual, 2 bytes -> sd_o[1:0] all 2'b11; underflow_o pulses twice.
- Standard, CSB raised after 5 rises -> partial_o and txn_end_o pulse together; no rx_valid_o.
- rst_ni asserted mid-byte (Quad, after 1 rise) -> all outputs 0 immediately. After release, a new transaction with 8'h7E is received correctly.
